// File: rtl/spi_start_seq_pkg.sv
// Shared definitions for the SPI start sequencer: register map, CONF bits,
// FSM state encoding and counter width.
package spi_start_seq_pkg;

  localparam int unsigned ADDR_VERSION   = 0;
  localparam int unsigned ADDR_START     = 1;
  localparam int unsigned ADDR_CONF      = 2;
  localparam int unsigned ADDR_DELAY_LO  = 3;
  localparam int unsigned ADDR_DELAY_HI  = 4;
  localparam int unsigned ADDR_PERIOD_LO = 5;
  localparam int unsigned ADDR_PERIOD_HI = 6;
  localparam int unsigned ADDR_REPEAT_LO = 7;
  localparam int unsigned ADDR_REPEAT_HI = 8;
  localparam int unsigned ADDR_COUNT_LO  = 9;
  localparam int unsigned ADDR_COUNT_HI  = 10;

  localparam int unsigned CONF_WAIT_SEN  = 0;
  localparam int unsigned CONF_ARM_EXT   = 1;

  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_PULSE,
    ST_WAITSEN,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_start_seq_core_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a one-cycle
// edge pulse whose polarity is selected by FALLING.
module sync_edge #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], d};
  end

  // sr[1] is the synchronised level, sr[2] its previous value
  assign pulse = FALLING ? (~sr[1] & sr[2]) : (sr[1] & ~sr[2]);

endmodule

// File: rtl/spi_start_seq_core.sv
// Bus-programmable sequencer generating EXT_START pulses for the SPI block:
// start delay, fixed-width pulses, programmable gap and optional SEN hand-off.
module spi_start_seq_core
  import spi_start_seq_pkg::*;
#(
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned PULSE_LEN = 8,
  parameter logic [7:0]  VERSION   = 8'd1
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 SEN_IN,
  input  logic                 TRIG_IN,
  output logic                 EXT_START,
  output logic                 BUSY
);

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_LEN - 1);

  logic               rst;
  logic               soft_rst;
  logic               start_wr;
  logic [1:0]         conf;
  logic [15:0]        delay_reg;
  logic [15:0]        period_reg;
  logic [15:0]        repeat_reg;
  logic [COUNT_W-1:0] count;
  logic [15:0]        cnt;
  logic               done;
  logic               sen_fall;
  logic               trig_rise;
  state_t             state;

  // The write strobe itself resets, so the soft reset is visible right after the write edge
  assign soft_rst = BUS_WR && (BUS_ADD == ABUSWIDTH'(ADDR_VERSION));
  assign rst      = BUS_RST || soft_rst;
  assign start_wr = BUS_WR && (BUS_ADD == ABUSWIDTH'(ADDR_START));

  sync_edge #(.FALLING(1'b1)) u_sen_sync (
    .clk   (BUS_CLK),
    .rst   (rst),
    .d     (SEN_IN),
    .pulse (sen_fall)
  );

  sync_edge #(.FALLING(1'b0)) u_trig_sync (
    .clk   (BUS_CLK),
    .rst   (rst),
    .d     (TRIG_IN),
    .pulse (trig_rise)
  );

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      conf       <= '0;
      delay_reg  <= '0;
      period_reg <= '0;
      repeat_reg <= '0;
    end else if (BUS_WR) begin
      case (BUS_ADD)
        ABUSWIDTH'(ADDR_CONF):      conf             <= BUS_DATA_IN[1:0];
        ABUSWIDTH'(ADDR_DELAY_LO):  delay_reg[7:0]   <= BUS_DATA_IN;
        ABUSWIDTH'(ADDR_DELAY_HI):  delay_reg[15:8]  <= BUS_DATA_IN;
        ABUSWIDTH'(ADDR_PERIOD_LO): period_reg[7:0]  <= BUS_DATA_IN;
        ABUSWIDTH'(ADDR_PERIOD_HI): period_reg[15:8] <= BUS_DATA_IN;
        ABUSWIDTH'(ADDR_REPEAT_LO): repeat_reg[7:0]  <= BUS_DATA_IN;
        ABUSWIDTH'(ADDR_REPEAT_HI): repeat_reg[15:8] <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      BUS_DATA_OUT <= '0;
    end else if (BUS_RD) begin
      case (BUS_ADD)
        ABUSWIDTH'(ADDR_VERSION):   BUS_DATA_OUT <= VERSION;
        ABUSWIDTH'(ADDR_START):     BUS_DATA_OUT <= {6'b0, done, BUSY};
        ABUSWIDTH'(ADDR_CONF):      BUS_DATA_OUT <= {6'b0, conf};
        ABUSWIDTH'(ADDR_DELAY_LO):  BUS_DATA_OUT <= delay_reg[7:0];
        ABUSWIDTH'(ADDR_DELAY_HI):  BUS_DATA_OUT <= delay_reg[15:8];
        ABUSWIDTH'(ADDR_PERIOD_LO): BUS_DATA_OUT <= period_reg[7:0];
        ABUSWIDTH'(ADDR_PERIOD_HI): BUS_DATA_OUT <= period_reg[15:8];
        ABUSWIDTH'(ADDR_REPEAT_LO): BUS_DATA_OUT <= repeat_reg[7:0];
        ABUSWIDTH'(ADDR_REPEAT_HI): BUS_DATA_OUT <= repeat_reg[15:8];
        ABUSWIDTH'(ADDR_COUNT_LO):  BUS_DATA_OUT <= count[7:0];
        ABUSWIDTH'(ADDR_COUNT_HI):  BUS_DATA_OUT <= count[15:8];
        default:                    BUS_DATA_OUT <= '0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      count     <= '0;
      done      <= 1'b0;
      EXT_START <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            count <= '0;
            done  <= 1'b0;
            cnt   <= delay_reg;
            BUSY  <= 1'b1;
            state <= conf[CONF_ARM_EXT] ? ST_ARMED : ST_DELAY;
          end
        end
        ST_ARMED: begin
          // DELAY is re-sampled here since it may have been rewritten while armed
          if (trig_rise) begin
            cnt   <= delay_reg;
            state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt == '0) begin
            EXT_START <= 1'b1;
            cnt       <= PULSE_LAST;
            count     <= count + 1'b1;
            state     <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            EXT_START <= 1'b0;
            if ((repeat_reg != '0) && (count == repeat_reg)) begin
              done  <= 1'b1;
              BUSY  <= 1'b0;
              state <= ST_IDLE;
            end else if (conf[CONF_WAIT_SEN]) begin
              state <= ST_WAITSEN;
            end else begin
              cnt   <= period_reg;
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAITSEN: begin
          // A synchronised falling edge implies SEN was high, so one edge covers both cases
          if (sen_fall) begin
            cnt   <= period_reg;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            EXT_START <= 1'b1;
            cnt       <= PULSE_LAST;
            count     <= count + 1'b1;
            state     <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          EXT_START <= 1'b0;
          BUSY      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
